// File: rtl/det_pkg.sv
//------------------------------------------------------------------------------
// det_pkg
// Shared constants and helpers for the det_4x4 front end.
//   ELEM_W_DEF : default element width in bits
//   N          : matrix order (4x4)
//   NUM_ELEM   : number of matrix elements (16)
//   MAT_W      : width of the packed matrix bus at the default element width
//   IDX_W      : width of the element index counter
//   state_t    : loader FSM state encoding (LOAD / WAIT / RESULT)
//   slot_lsb   : bit offset of element k inside the packed matrix bus
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package det_pkg;

    localparam int unsigned ELEM_W_DEF = 8;
    localparam int unsigned N          = 4;
    localparam int unsigned NUM_ELEM   = N * N;
    localparam int unsigned MAT_W      = NUM_ELEM * ELEM_W_DEF;
    localparam int unsigned IDX_W      = 4;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        WAIT   = 2'd1,
        RESULT = 2'd2
    } state_t;

    // Element 0 sits in the most significant slot, element 15 in the least.
    function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned elem_w);
        return (NUM_ELEM - 1 - k) * elem_w;
    endfunction

endpackage

// File: rtl/det_4x4_loader.sv
//------------------------------------------------------------------------------
// det_4x4_loader
// Byte-serial front end for det_4x4. Collects 16 row-major elements from a
// valid/ready stream, packs them onto the matrix bus, waits DET_LAT edges for
// det_4x4 to settle, captures the determinant and overflow flag, and returns
// them over a valid/ready result handshake.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active high
//   in_valid   in   element stream valid
//   in_data    in   element, index k = row*4 + col
//   in_ready   out  loader accepts an element (LOAD state, not in reset)
//   mat_A      out  packed matrix, element k at [MAT_W-1-k*ELEM_W -: ELEM_W]
//   mat_valid  out  mat_A complete and held stable
//   det_in     in   det_4x4 determinant (signed)
//   ovf_in     in   det_4x4 overflow flag
//   res_valid  out  result available
//   res_det    out  captured determinant (signed, unmodified)
//   res_ovf    out  captured overflow flag
//   res_ready  in   result consumer ready
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module det_4x4_loader
    import det_pkg::*;
#(
    parameter int unsigned ELEM_W  = det_pkg::ELEM_W_DEF,
    parameter int unsigned DET_LAT = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [ELEM_W-1:0]            in_data,
    output logic                         in_ready,
    output logic [NUM_ELEM*ELEM_W-1:0]   mat_A,
    output logic                         mat_valid,
    input  logic [ELEM_W-1:0]            det_in,
    input  logic                         ovf_in,
    output logic                         res_valid,
    output logic [ELEM_W-1:0]            res_det,
    output logic                         res_ovf,
    input  logic                         res_ready
);

    localparam int unsigned LP_MAT_W = NUM_ELEM * ELEM_W;
    localparam int unsigned CNT_W    = $clog2(DET_LAT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ELEM - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(DET_LAT - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_wait_cnt;
    logic [LP_MAT_W-1:0]   r_mat_A;
    logic                  r_mat_valid;
    logic                  r_res_valid;
    logic [ELEM_W-1:0]     r_res_det;
    logic                  r_res_ovf;

    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_last_elem;
    logic                  w_capture;
    logic                  w_release;

    // Handshake qualifiers and next-state decode for the loader FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_accept    = 1'b0;
        w_last_elem = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;

        case (r_state)
            LOAD: begin
                // in_ready drops combinationally with rst so nothing is
                // accepted on the edge that applies reset.
                w_in_ready  = ~rst;
                w_accept    = in_valid & ~rst;
                w_last_elem = w_accept & (r_idx == LAST_IDX);
                if (w_last_elem) begin
                    w_state_nxt = WAIT;
                end else begin
                    w_state_nxt = LOAD;
                end
            end
            WAIT: begin
                w_capture = (r_wait_cnt == LAST_WAIT);
                if (w_capture) begin
                    w_state_nxt = RESULT;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            RESULT: begin
                w_release = r_res_valid & res_ready;
                if (w_release) begin
                    w_state_nxt = LOAD;
                end else begin
                    w_state_nxt = RESULT;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Element index: advances per accepted element, wraps only on the last one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (w_last_elem) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= r_idx + IDX_W'(1);
        end else begin
            r_idx <= r_idx;
        end
    end

    // Matrix slots: written in place, never cleared between matrices, so a
    // slot keeps its old value until the new stream reaches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mat_A <= '0;
        end else begin
            for (int k = 0; k < NUM_ELEM; k++) begin
                if (w_accept && (r_idx == IDX_W'(k))) begin
                    r_mat_A[slot_lsb(k, ELEM_W) +: ELEM_W] <= in_data;
                end
            end
        end
    end

    // Latency counter: cleared when the matrix completes, counts while waiting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (w_last_elem) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end

    // mat_valid spans from the last accept until the result is consumed,
    // which is the whole window in which det_4x4 output is meaningful.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mat_valid <= 1'b0;
        end else if (w_last_elem) begin
            r_mat_valid <= 1'b1;
        end else if (w_release) begin
            r_mat_valid <= 1'b0;
        end else begin
            r_mat_valid <= r_mat_valid;
        end
    end

    // Result capture and hold; det_in is passed through untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_det   <= '0;
            r_res_ovf   <= 1'b0;
        end else if (w_capture) begin
            r_res_valid <= 1'b1;
            r_res_det   <= det_in;
            r_res_ovf   <= ovf_in;
        end else if (w_release) begin
            r_res_valid <= 1'b0;
            r_res_det   <= r_res_det;
            r_res_ovf   <= r_res_ovf;
        end else begin
            r_res_valid <= r_res_valid;
            r_res_det   <= r_res_det;
            r_res_ovf   <= r_res_ovf;
        end
    end

    assign in_ready  = w_in_ready;
    assign mat_A     = r_mat_A;
    assign mat_valid = r_mat_valid;
    assign res_valid = r_res_valid;
    assign res_det   = r_res_det;
    assign res_ovf   = r_res_ovf;

endmodule
